// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock monitor: FSM states and default sizing.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_EXP_HALF   = 3;
  localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/clk_div_edge.sv
// Registers the divided wave once and flags rising/falling transitions against that copy.
module clk_div_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic sig_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q;
  assign fall = ~sig_in & sig_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Times the high and low phases of a divided clock, reports full periods,
// flags off-length phases and holds a lock flag after a run of good phases.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_HALF   = DEF_EXP_HALF,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             period_valid,
  output logic             mismatch,
  output logic             timeout,
  output logic             locked
);

  localparam int                RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  EXP_LEN  = CNT_W'(EXP_HALF);
  localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_COUNT);

  logic             rise;
  logic             fall;
  logic             sig_q;
  logic             toggle;
  logic             capture;
  logic             cap_match;
  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] match_run;
  logic             have_high;
  mon_state_t       state;

  clk_div_edge u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall),
    .sig_q  (sig_q)
  );

  // A phase is captured only when it started from a known edge, never from IDLE.
  always_comb begin
    toggle    = rise | fall;
    capture   = ((state == HIGH) && fall) || ((state == LOW) && rise);
    cap_match = (cnt == EXP_LEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      match_run    <= '0;
      have_high    <= 1'b0;
      high_len     <= '0;
      low_len      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;

      if (toggle) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      // Lock run saturates at LOCK_COUNT so a long good stretch keeps lock asserted.
      if (capture) begin
        if (cap_match) begin
          if (match_run != RUN_LOCK) begin
            match_run <= match_run + 1'b1;
          end
          if (match_run >= RUN_LOCK - 1'b1) begin
            locked <= 1'b1;
          end
        end else begin
          mismatch  <= 1'b1;
          match_run <= '0;
          locked    <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state     <= HIGH;
            have_high <= 1'b0;
          end else if (fall) begin
            state     <= LOW;
            have_high <= 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            high_len  <= cnt;
            have_high <= 1'b1;
            state     <= LOW;
          end else if (cnt == CNT_MAX) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_run <= '0;
            state     <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            low_len <= cnt;
            if (have_high) begin
              period       <= {1'b0, high_len} + {1'b0, cnt};
              period_valid <= 1'b1;
            end
            state <= HIGH;
          end else if (cnt == CNT_MAX) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_run <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measures a divided clock produced inside the clk domain. Samples the single-bit square wave, times every high and low phase in clk cycles, and reports each full period. Flags phases that differ from the expected half-period and asserts a lock indication after a run of correct phases. Sits next to the clock divider as its checking and receiving end, both in silicon self-test and in the bench.

## Interface
- CNT_W, 8: phase-counter width. Longest measurable phase is 2^CNT_W-1 cycles.
- EXP_HALF, 3: expected phase length in clk cycles, 1 ≤ EXP_HALF ≤ 2^CNT_W-2.
- LOCK_COUNT, 4: number of consecutive matching phases required to assert locked, ≥1.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- sig_in  in  1  divided wave, synchronous to clk.
- high_len  out  CNT_W  length of the last complete high phase.
- low_len  out  CNT_W  length of the last complete low phase.
- period  out  CNT_W+1  high_len+low_len of the last full period.
- period_valid  out  1  one-cycle pulse when period updates.
- mismatch  out  1  one-cycle pulse when a captured phase ≠ EXP_HALF.
- timeout  out  1  one-cycle pulse when the counter saturates.
- locked  out  1  level: LOCK_COUNT consecutive phases equal EXP_HALF.

## Operation
- sig_q is sig_in delayed one cycle.
- Edge cycle: sig_in != sig_q. A rise is sig_in=1; a fall is sig_in=0.
- cnt:
  - on an edge cycle, cnt <= 1;
  - otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - In an edge cycle, cnt equals the number of cycles since the previous edge, which is the phase length.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: waits for any edge. Rise → HIGH; fall → LOW. No capture, because the preceding phase is partial. have_high is cleared.
  - HIGH:
    - Fall → capture high_len <= cnt, set have_high, go to LOW.
    - Rise cannot occur here.
  - LOW: rise → capture low_len <= cnt, go to HIGH. If have_high is set, period <= high_len + cnt (CNT_W+1 bits, no overflow) and period_valid pulses.
  - HIGH or LOW with cnt = 2^CNT_W-1 and no edge: timeout pulses, locked is cleared, match_run is cleared, go to IDLE.
- Every capture also runs the lock check:
  - Captured length ≠ EXP_HALF: mismatch pulses, match_run <= 0, locked <= 0.
  - Captured length = EXP_HALF: match_run <= min(match_run+1, LOCK_COUNT). locked <= 1 when the new match_run = LOCK_COUNT.
- high_len, low_len and period hold their values between captures, and across timeout.

## Timing
- Every output is registered.
- Capture outputs and pulses are updated at the posedge that ends the edge cycle and are visible in the following cycle.
- Latency: one cycle from sig_in toggling at the sampling edge.
- Pulses last exactly one cycle. Pulses can coincide:
  - mismatch and period_valid can assert in the same cycle;
  - timeout never coincides with either.
- Reset values: every output is 0, state=IDLE, cnt=0, sig_q=0, match_run=0, have_high=0.
- Reset mid-phase discards all measurement state immediately.
- On the first cycle after reset, sig_in=1 counts as a rise, because sig_q=0.
- Saturation: cnt holds at its maximum. A timeout on a phase of exactly 2^CNT_W-1 cycles takes priority over an edge arriving one cycle later. That edge is then handled from IDLE.

## Structure
- Package clk_div_pkg holds the FSM state enum and the default values of CNT_W, EXP_HALF and LOCK_COUNT.
- One sub-module: clk_div_edge with ports clk, reset, sig_in and outputs rise, fall, registered sig_q.
- The counter, FSM and lock logic live in clk_div_monitor.

## Test plan
- sig_in toggles every 3 cycles (divider behaviour), defaults → after the first partial phase:
  - high_len=3 and low_len=3;
  - period=6 with period_valid once every 6 cycles;
  - locked rises with the 4th capture;
  - mismatch is never asserted.
- High 2 / low 4 cycles → high_len=2, low_len=4, period=6, mismatch every capture, locked stays 0.
- Locked, then a single 5-cycle high phase → mismatch pulse, locked drops the same cycle. Lock is regained after 4 further correct phases.
- sig_in held at 1 for 300 cycles after locking → timeout pulses 255 cycles after the last edge, locked=0, FSM returns to IDLE. The next edge produces no capture.
- Reset asserted for 3 cycles in mid-phase while locked → every output is 0 during and after reset. The first capture after reset comes only after a partial phase.
- EXP_HALF=1, sig_in toggling every cycle → every capture is 1, period=2, period_valid every 2 cycles, locked after 4 captures.
